seg_scan_display: RTL and testbench

// - Parametrised multiplexed seven-segment driver for the board top; replaces divider + fixed 4-digit output pair.
// - Internal scan-tick divider, N digits, tear-free frame-boundary update, leading-zero suppression, PWM brightness.
// - Sits between CPU-exported display register and board pins (sev_seg/an/dp).

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_scan_display_if.sv | 27 ++
 rtl/seg_scan_display_scan_tick_gen.sv | 29 ++
 rtl/seg_scan_display.sv | 142 ++++++++++++++
 tb/tb_seg_scan_display.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Purpose: shared seven-segment encoding for scanned display peripherals.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package seg_pkg;

  // All segments dark, active-high {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex nibble to active-high {g,f,e,d,c,b,a}. 6 keeps segment a, 9 keeps segment d.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Purpose: display register side (value/strobe/live controls) plus board pin side of the scanner.
// Latency: n/a (wiring only).
// Backpressure: none; load is a strobe that is always accepted.
interface seg_scan_display_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_suppress;
  logic [3:0]              brightness;
  logic [6:0]              sev_seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output value, load, dp_mask, digit_en, lz_suppress, brightness,
    input  sev_seg, an, dp, frame_start
  );

  modport slave (
    input  value, load, dp_mask, digit_en, lz_suppress, brightness,
    output sev_seg, an, dp, frame_start
  );
endinterface

// File: rtl/seg_scan_display_scan_tick_gen.sv
// Purpose: free-running slot divider; tick flags the last cycle of each TICK_DIV-cycle slot.
// Latency: tick is combinational from the registered counter.
// Backpressure: none; runs every cycle.
module scan_tick_gen #(
  parameter int unsigned TICK_DIV = 416667,
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic          CLK,
  input  logic          rst,
  output logic          tick,
  output logic [CW-1:0] tick_cnt
);

  localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);

  assign tick = (tick_cnt == LAST_CNT);

  // Count 0..TICK_DIV-1 and wrap on the tick cycle.
  always_ff @(posedge CLK) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Purpose: multiplexed N-digit seven-segment driver with frame-aligned update, LZ blanking and PWM dimming.
// Latency: pins are registered, one cycle after the scan/PWM state they reflect.
// Backpressure: none; load is always taken into staging and committed at the next frame wrap.
module seg_scan_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 416667,
  parameter int unsigned BLANK_CYC  = 64,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic               CLK,
  input  logic               rst,
  seg_scan_display_if.slave  bus
);
  import seg_pkg::*;

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0]         LAST_DIGIT = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]         BLANK_END  = CW'(BLANK_CYC);
  localparam logic [6:0]            SEG_POL    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_POL     = ACTIVE_LOW ? '1 : '0;

  logic                         tick;
  logic [CW-1:0]                tick_cnt;
  logic [IW-1:0]                digit_idx;
  logic [3:0]                   pwm_cnt;
  logic                         wrap;

  logic [NUM_DIGITS-1:0][3:0]   stg_value;
  logic [NUM_DIGITS-1:0]        stg_dp;
  logic [NUM_DIGITS-1:0]        stg_en;
  logic                         pending;
  logic [NUM_DIGITS-1:0][3:0]   sh_value;
  logic [NUM_DIGITS-1:0]        sh_dp;
  logic [NUM_DIGITS-1:0]        sh_en;

  logic [NUM_DIGITS-1:0]        suppressed;
  logic                         slot_on;
  logic [NUM_DIGITS-1:0]        an_act;
  logic [6:0]                   seg_act;
  logic                         dp_act;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK      (CLK),
    .rst      (rst),
    .tick     (tick),
    .tick_cnt (tick_cnt)
  );

  assign wrap = tick && (digit_idx == LAST_DIGIT);

  // Step the scanned digit once per slot; PWM phase counter runs every cycle.
  always_ff @(posedge CLK) begin
    if (rst) begin
      digit_idx <= '0;
      pwm_cnt   <= 4'd0;
    end else begin
      if (tick) begin
        digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
      end
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  // Stage loads; commit to the displayed shadow only at a frame wrap so a frame is never torn.
  always_ff @(posedge CLK) begin
    if (rst) begin
      stg_value <= '0;
      stg_dp    <= '0;
      stg_en    <= '0;
      pending   <= 1'b0;
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
    end else begin
      if (bus.load) begin
        stg_value <= bus.value;
        stg_dp    <= bus.dp_mask;
        stg_en    <= bus.digit_en;
      end
      if (wrap) begin
        // A load landing on the wrap cycle bypasses staging and shows in the frame just starting.
        if (bus.load) begin
          sh_value <= bus.value;
          sh_dp    <= bus.dp_mask;
          sh_en    <= bus.digit_en;
        end else if (pending) begin
          sh_value <= stg_value;
          sh_dp    <= stg_dp;
          sh_en    <= stg_en;
        end
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero map: a digit is blank when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    suppressed = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run      = zero_run && (sh_value[i] == 4'h0);
      suppressed[i] = bus.lz_suppress && zero_run && (i != 0);
    end
  end

  // Active-high pin values for the current scan position before polarity and registering.
  always_comb begin
    an_act  = '0;
    slot_on = (tick_cnt >= BLANK_END) && (pwm_cnt <= bus.brightness);
    if (slot_on) begin
      an_act[digit_idx] = 1'b1;
    end
    if (sh_en[digit_idx] && !suppressed[digit_idx]) begin
      seg_act = hex_to_seg(sh_value[digit_idx]);
    end else begin
      seg_act = SEG_OFF;
    end
    dp_act = sh_dp[digit_idx];
  end

  // Register pins with board polarity; reset drives everything dark.
  always_ff @(posedge CLK) begin
    if (rst) begin
      bus.sev_seg     <= SEG_POL;
      bus.an          <= AN_POL;
      bus.dp          <= ACTIVE_LOW;
      bus.frame_start <= 1'b0;
    end else begin
      bus.sev_seg     <= seg_act ^ SEG_POL;
      bus.an          <= an_act ^ AN_POL;
      bus.dp          <= dp_act ^ ACTIVE_LOW;
      bus.frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Purpose: self-checking bench for seg_scan_display (4 digits, 8-cycle slots, 2 blank cycles, active-low).
// Latency: a cycle model pushes expected pins each edge; they are popped and compared on the next falling edge.
// Backpressure: n/a.
module tb_seg_scan_display;
  localparam int ND = 4;
  localparam int TD = 8;
  localparam int BC = 2;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  seg_scan_display_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_display #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD),
    .BLANK_CYC  (BC),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } outs_t;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      en;
    logic [3:0]      dpm;
    logic            lz;
    logic [3:0][6:0] seg;   // expected pins per digit, [3] leftmost
    logic [3:0]      dpo;   // expected dp pin per digit
  } vec_t;

  outs_t sb_q[$];

  // Reference model state
  int          m_tick, m_idx;
  logic [3:0]  m_pwm;
  logic [15:0] m_stg_val, m_sh_val;
  logic [3:0]  m_stg_dp, m_stg_en, m_sh_dp, m_sh_en;
  logic        m_pend;

  // Active-low segment pattern of a hex digit (segment lit = 0).
  function automatic logic [6:0] hex_al(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: expected pins for this edge come from the state held before it.
  always @(posedge CLK) begin
    outs_t e;
    logic  wrap;
    logic  supp;
    if (rst) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
      m_tick = 0; m_idx = 0; m_pwm = 4'd0; m_pend = 1'b0;
      m_stg_val = '0; m_stg_dp = '0; m_stg_en = '0;
      m_sh_val = '0; m_sh_dp = '0; m_sh_en = '0;
    end else begin
      e.fs  = (m_tick == TD - 1) && (m_idx == ND - 1);
      e.an  = (m_tick >= BC && m_pwm <= bus.brightness) ? ~(4'b0001 << m_idx) : 4'hF;
      supp  = bus.lz_suppress && (m_idx != 0) && ((m_sh_val >> (4 * m_idx)) == 16'h0);
      e.seg = (m_sh_en[m_idx] && !supp) ? hex_al(m_sh_val[m_idx*4 +: 4]) : 7'h7F;
      e.dp  = ~m_sh_dp[m_idx];
      wrap  = e.fs;
      if (bus.load) begin
        m_stg_val = bus.value; m_stg_dp = bus.dp_mask; m_stg_en = bus.digit_en;
        if (wrap) begin
          m_sh_val = bus.value; m_sh_dp = bus.dp_mask; m_sh_en = bus.digit_en;
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end else if (wrap && m_pend) begin
        m_sh_val = m_stg_val; m_sh_dp = m_stg_dp; m_sh_en = m_stg_en;
        m_pend = 1'b0;
      end
      if (m_tick == TD - 1) m_idx = (m_idx + 1) % ND;
      m_tick = (m_tick + 1) % TD;
      m_pwm  = m_pwm + 4'd1;
    end
    sb_q.push_back(e);
  end

  // Scoreboard: compare each registered output set away from the active edge.
  always @(negedge CLK) begin
    outs_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_an",  32'(bus.an),          32'(e.an));
      check("sb_seg", 32'(bus.sev_seg),     32'(e.seg));
      check("sb_dp",  32'(bus.dp),          32'(e.dp));
      check("sb_fs",  32'(bus.frame_start), 32'(e.fs));
    end
  end

  task automatic wait_fs(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (bus.frame_start) begin found = 1'b1; break; end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL %s: frame_start stayed 0, expected a pulse within 100 cycles", name);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (bus.an == target) begin found = 1'b1; break; end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL %s: an last %b, expected %b within 100 cycles", name, bus.an, target);
    end
  endtask

  task automatic count_on(input logic [3:0] br, input int exp_cnt, input string name);
    int cnt = 0;
    @(negedge CLK); bus.brightness = br;
    repeat (4) @(negedge CLK);
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (bus.an != 4'hF) cnt++;
    end
    check(name, 32'(cnt), 32'(exp_cnt));
  endtask

  vec_t vecs[7];

  initial begin
    bit seen;
    vecs[0] = '{16'h1234, 4'hF, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
    vecs[1] = '{16'h0042, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'hF};
    vecs[2] = '{16'h0000, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
    vecs[3] = '{16'h0042, 4'hF, 4'h0, 1'b0, {7'h40, 7'h40, 7'h19, 7'h24}, 4'hF};
    vecs[4] = '{16'h89AB, 4'hA, 4'h5, 1'b0, {7'h00, 7'h7F, 7'h08, 7'h7F}, 4'hA};
    vecs[5] = '{16'h00C0, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h46, 7'h40}, 4'hF};
    vecs[6] = '{16'h0D0E, 4'hF, 4'h8, 1'b1, {7'h7F, 7'h21, 7'h40, 7'h06}, 4'h7};

    bus.value = '0; bus.load = 1'b0; bus.dp_mask = '0; bus.digit_en = '0;
    bus.lz_suppress = 1'b0; bus.brightness = 4'hF;
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    check("post_reset_an",  32'(bus.an),          32'hF);
    check("post_reset_seg", 32'(bus.sev_seg),     32'h7F);
    check("post_reset_dp",  32'(bus.dp),          32'h1);
    check("post_reset_fs",  32'(bus.frame_start), 32'h0);

    // Table-driven frames: load, wait for the commit, read every digit.
    for (int v = 0; v < 7; v++) begin
      @(negedge CLK);
      bus.value = vecs[v].value; bus.digit_en = vecs[v].en;
      bus.dp_mask = vecs[v].dpm; bus.lz_suppress = vecs[v].lz; bus.load = 1'b1;
      @(negedge CLK); bus.load = 1'b0;
      wait_fs("vec_fs");
      for (int d = 0; d < ND; d++) begin
        wait_an(~(4'b0001 << d), "vec_an");
        check($sformatf("vec%0d_seg_d%0d", v, d), 32'(bus.sev_seg), 32'(vecs[v].seg[d]));
        check($sformatf("vec%0d_dp_d%0d", v, d),  32'(bus.dp),      32'(vecs[v].dpo[d]));
      end
    end

    // Mid-frame load must not disturb the frame in progress.
    wait_fs("mid_fs");
    repeat (4) @(negedge CLK);
    bus.value = 16'hAAAA; bus.digit_en = 4'hF; bus.dp_mask = 4'h0; bus.load = 1'b1;
    @(negedge CLK); bus.load = 1'b0;
    wait_an(4'b1101, "mid_an1");
    check("mid_keep_d1_seg", 32'(bus.sev_seg), 32'h40);
    wait_an(4'b0111, "mid_an3");
    check("mid_keep_d3_seg", 32'(bus.sev_seg), 32'h7F);
    check("mid_keep_d3_dp",  32'(bus.dp),      32'h0);
    wait_fs("mid_fs2");
    wait_an(4'b1110, "mid_an0");
    check("new_frame_d0_seg", 32'(bus.sev_seg), 32'h08);

    // Load on the wrap edge itself shows in the frame that starts there.
    wait_fs("wrap_fs_a");
    repeat (31) @(negedge CLK);
    bus.value = 16'h5555; bus.load = 1'b1;
    @(negedge CLK); bus.load = 1'b0;
    check("wrap_fs", 32'(bus.frame_start), 32'h1);
    wait_an(4'b1110, "wrap_an0");
    check("wrap_load_d0_seg", 32'(bus.sev_seg), 32'h12);

    // Brightness: anode-on cycles in 64 given 8-cycle slots with 2 blank cycles.
    count_on(4'h0, 0,  "bright0_on");
    count_on(4'h7, 24, "bright7_on");
    count_on(4'hB, 32, "bright11_on");
    @(negedge CLK); bus.brightness = 4'hF;

    // Reset in the middle of digit 2's slot.
    wait_an(4'b1011, "rst_an2");
    rst = 1'b1;
    @(negedge CLK);
    check("midrst_an",  32'(bus.an),          32'hF);
    check("midrst_seg", 32'(bus.sev_seg),     32'h7F);
    check("midrst_dp",  32'(bus.dp),          32'h1);
    check("midrst_fs",  32'(bus.frame_start), 32'h0);
    @(negedge CLK);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.an != 4'hF) begin seen = 1'b1; break; end
    end
    check("resume_seen",  32'(seen),        32'h1);
    check("resume_an",    32'(bus.an),      32'hE);
    check("resume_blank", 32'(bus.sev_seg), 32'h7F);

    @(negedge CLK);
    bus.value = 16'h0001; bus.digit_en = 4'hF; bus.load = 1'b1;
    @(negedge CLK); bus.load = 1'b0;
    wait_fs("after_rst_fs");
    wait_an(4'b1110, "after_rst_an0");
    check("after_rst_d0_seg", 32'(bus.sev_seg), 32'h79);

    repeat (4) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
